// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the PC generator.
// Holds the sequencer state encoding and select-width sizing.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } pc_state_e;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pc_src_mux.sv
// Next-PC source selector: source 0 is the sequential PC,
// sources 1..NUM_SRC-1 come from external targets.
module pc_src_mux
    import pc_gen_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
) (
    input  logic [sel_w(NUM_SRC)-1:0]     sel,
    input  logic [XLEN-1:0]               seq_pc,
    input  logic [NUM_SRC-1:1][XLEN-1:0]  srcs,
    output logic [XLEN-1:0]               tgt,
    output logic                          redir
);

    // Out-of-range selects fall through to the sequential PC.
    always_comb begin
        tgt   = seq_pc;
        redir = 1'b0;
        for (int i = 1; i < NUM_SRC; i++) begin
            if (int'(sel) == i) begin
                tgt   = srcs[i];
                redir = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator with stall-tolerant redirect capture
// and a sticky misaligned-target flag.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                XLEN       = 32,
    parameter int                NUM_SRC    = 4,
    parameter logic [XLEN-1:0]   RESET_VEC  = XLEN'(32'h0000_0000),
    parameter int                ALIGN_BITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [sel_w(NUM_SRC)-1:0]     pc_sel,
    input  logic [NUM_SRC-1:1][XLEN-1:0]  pc_src_in,
    input  logic                          pc_ld,
    input  logic                          fetch_rdy,
    input  logic                          mis_clr,
    output logic [XLEN-1:0]               pc_out,
    output logic                          pc_valid,
    output logic                          pc_pend,
    output logic                          pc_misalign
);

    localparam logic [XLEN-1:0] STEP  = XLEN'(1) << ALIGN_BITS;
    localparam logic [XLEN-1:0] AMASK = STEP - XLEN'(1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            mis_q, mis_d, mis_set;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] tgt;
    logic            redir;
    logic            misal;
    logic            new_ok;

    assign seq_pc = pc_q + STEP;

    pc_src_mux #(
        .NUM_SRC (NUM_SRC),
        .XLEN    (XLEN)
    ) u_mux (
        .sel    (pc_sel),
        .seq_pc (seq_pc),
        .srcs   (pc_src_in),
        .tgt    (tgt),
        .redir  (redir)
    );

    assign misal  = |(tgt & AMASK);
    assign new_ok = pc_ld && redir && !misal;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        mis_set = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (pc_ld && (fetch_rdy || redir)) begin
                    if (misal) begin
                        mis_set = 1'b1;
                    end else if (fetch_rdy) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                // A misaligned redirect never displaces the held target.
                mis_set = pc_ld && redir && misal;
                if (fetch_rdy) begin
                    pc_d    = new_ok ? tgt : pend_q;
                    pend_d  = '0;
                    state_d = S_RUN;
                end else if (new_ok) begin
                    pend_d = tgt;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        mis_d = mis_set | (mis_q & ~mis_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_out      = pc_q;
    assign pc_valid    = (state_q != S_BOOT);
    assign pc_pend     = (state_q == S_PEND);
    assign pc_misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
// Each scenario task drives vectors and checks inline.
module tb_pc_gen;

    logic             clk;
    logic             rst_n;
    logic [1:0]       pc_sel;
    logic [3:1][31:0] pc_src_in;
    logic             pc_ld;
    logic             fetch_rdy;
    logic             mis_clr;
    logic [31:0]      pc_out;
    logic             pc_valid;
    logic             pc_pend;
    logic             pc_misalign;

    int errors = 0;
    int checks = 0;

    pc_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .pc_src_in   (pc_src_in),
        .pc_ld       (pc_ld),
        .fetch_rdy   (fetch_rdy),
        .mis_clr     (mis_clr),
        .pc_out      (pc_out),
        .pc_valid    (pc_valid),
        .pc_pend     (pc_pend),
        .pc_misalign (pc_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pc_ld = 1'b0;
        fetch_rdy = 1'b0;
        mis_clr = 1'b0;
        pc_sel = 2'd0;
        pc_src_in = '0;
        step();
        step();
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0);
        end
        checks++;
        if ({pc_valid, pc_pend, pc_misalign} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {pc_valid, pc_pend, pc_misalign});
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_valid: got %b want 0", pc_valid);
        end
        step();
        checks++;
        if (pc_valid !== 1'b1 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL run_valid: got v=%b pc=%h want v=1 pc=0",
                     pc_valid, pc_out);
        end
    endtask

    task automatic test_seq();
        logic [31:0] exp [3];
        exp[0] = 32'd4;
        exp[1] = 32'd8;
        exp[2] = 32'd12;
        pc_ld = 1'b1;
        pc_sel = 2'd0;
        fetch_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc_out !== exp[i]) begin
                errors++;
                $display("FAIL seq_%0d: got %h want %h", i, pc_out, exp[i]);
            end
        end
        pc_ld = 1'b0;
        fetch_rdy = 1'b0;
        pc_ld = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'd12 || pc_pend !== 1'b0) begin
            errors++;
            $display("FAIL seq_drop: got pc=%h pend=%b want pc=c pend=0",
                     pc_out, pc_pend);
        end
        pc_ld = 1'b0;
    endtask

    task automatic test_redirect();
        pc_ld = 1'b1;
        pc_sel = 2'd2;
        pc_src_in[2] = 32'h100;
        fetch_rdy = 1'b0;
        step();
        checks++;
        if (pc_pend !== 1'b1 || pc_out !== 32'd12) begin
            errors++;
            $display("FAIL redir_hold: got pend=%b pc=%h want 1/c",
                     pc_pend, pc_out);
        end
        pc_sel = 2'd1;
        pc_src_in[1] = 32'h200;
        step();
        pc_sel = 2'd0;
        step();
        checks++;
        if (pc_pend !== 1'b1 || pc_out !== 32'd12) begin
            errors++;
            $display("FAIL redir_over: got pend=%b pc=%h want 1/c",
                     pc_pend, pc_out);
        end
        pc_ld = 1'b0;
        fetch_rdy = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'h200 || pc_pend !== 1'b0) begin
            errors++;
            $display("FAIL redir_apply: got pc=%h pend=%b want 200/0",
                     pc_out, pc_pend);
        end
    endtask

    task automatic test_back_to_back();
        pc_ld = 1'b1;
        pc_sel = 2'd2;
        pc_src_in[2] = 32'h300;
        fetch_rdy = 1'b0;
        step();
        pc_sel = 2'd3;
        pc_src_in[3] = 32'h400;
        fetch_rdy = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'h400 || pc_pend !== 1'b0) begin
            errors++;
            $display("FAIL b2b_newest: got pc=%h pend=%b want 400/0",
                     pc_out, pc_pend);
        end
        pc_ld = 1'b0;
    endtask

    task automatic test_misalign();
        pc_ld = 1'b1;
        pc_sel = 2'd2;
        pc_src_in[2] = 32'h102;
        fetch_rdy = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'h400 || pc_misalign !== 1'b1) begin
            errors++;
            $display("FAIL mis_set: got pc=%h mis=%b want 400/1",
                     pc_out, pc_misalign);
        end
        mis_clr = 1'b1;
        fetch_rdy = 1'b0;
        step();
        checks++;
        if (pc_misalign !== 1'b1 || pc_pend !== 1'b0) begin
            errors++;
            $display("FAIL mis_setwins: got mis=%b pend=%b want 1/0",
                     pc_misalign, pc_pend);
        end
        pc_ld = 1'b0;
        step();
        checks++;
        if (pc_misalign !== 1'b0 || pc_out !== 32'h400) begin
            errors++;
            $display("FAIL mis_clr: got mis=%b pc=%h want 0/400",
                     pc_misalign, pc_out);
        end
        mis_clr = 1'b0;
    endtask

    task automatic test_wrap();
        pc_ld = 1'b1;
        pc_sel = 2'd1;
        pc_src_in[1] = 32'hFFFF_FFFC;
        fetch_rdy = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_load: got %h want fffffffc", pc_out);
        end
        pc_sel = 2'd0;
        step();
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL wrap_seq: got %h want 0", pc_out);
        end
        pc_ld = 1'b0;
    endtask

    task automatic test_reset_pend();
        pc_ld = 1'b1;
        pc_sel = 2'd2;
        pc_src_in[2] = 32'h500;
        fetch_rdy = 1'b0;
        step();
        checks++;
        if (pc_pend !== 1'b1) begin
            errors++;
            $display("FAIL rp_pend: got %b want 1", pc_pend);
        end
        rst_n = 1'b0;
        pc_sel = 2'd1;
        pc_src_in[1] = 32'h600;
        fetch_rdy = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'h0 || pc_pend !== 1'b0 || pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL rp_reset: got pc=%h pend=%b v=%b want 0/0/0",
                     pc_out, pc_pend, pc_valid);
        end
        rst_n = 1'b1;
        pc_ld = 1'b0;
        step();
        step();
        checks++;
        if (pc_out !== 32'h0 || pc_pend !== 1'b0 || pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL rp_discard: got pc=%h pend=%b v=%b want 0/0/1",
                     pc_out, pc_pend, pc_valid);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_redirect();
        test_back_to_back();
        test_misalign();
        test_wrap();
        test_reset_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 4, meaning next-PC source count, legal range 2..16.
REQ-003 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning PC value after reset.
REQ-004 SHALL have parameter ALIGN_BITS, default 2, meaning low PC bits that must be zero.
REQ-005 SHALL have port CLK  in  1  meaning single clock, rising edge.
REQ-006 SHALL have port RST_N  in  1  meaning reset; synchronous and active-low.
REQ-007 SHALL have port PC_SEL  in  $clog2(NUM_SRC)  meaning next-PC source select.
REQ-008 SHALL have port PC_SRC_IN  in  (NUM_SRC-1)xXLEN  meaning external targets for sources 1..NUM_SRC-1.
REQ-009 SHALL have port PC_LD  in  1  meaning request to advance the PC this cycle.
REQ-010 SHALL have port FETCH_RDY  in  1  meaning fetch stage accepts a new PC.
REQ-011 SHALL have port MIS_CLR  in  1  meaning clear sticky misalign flag.
REQ-012 SHALL have port PC_OUT  out  XLEN  meaning current registered PC.
REQ-013 SHALL have port PC_VALID  out  1  meaning PC_OUT is a valid fetch address.
REQ-014 SHALL have port PC_PEND  out  1  meaning a redirect target is held pending.
REQ-015 SHALL have port PC_MISALIGN  out  1  meaning sticky misaligned-target flag.

Function
REQ-016 SHALL compute source 0 internally as PC_OUT + (1 << ALIGN_BITS), wrapping modulo 2^XLEN.
REQ-017 SHALL treat PC_SEL >= NUM_SRC as selecting source 0.
REQ-018 SHALL implement states S_BOOT, S_RUN, S_PEND.
REQ-019 S_BOOT: PC_VALID=0; next cycle SHALL go to S_RUN unconditionally, with PC_OUT unchanged.
REQ-020 S_RUN: on PC_LD and FETCH_RDY, PC_OUT SHALL take the selected target at the next edge (1-cycle latency).
REQ-021 S_RUN: on PC_LD, !FETCH_RDY and PC_SEL!=0, SHALL capture the target in a pending register, go to S_PEND, and leave PC_OUT unchanged.
REQ-022 S_RUN: PC_LD with PC_SEL==0 and !FETCH_RDY SHALL be dropped, with no state change.
REQ-023 S_PEND: a new PC_LD with PC_SEL!=0 SHALL overwrite the pending target; the newest redirect wins.
REQ-024 S_PEND with FETCH_RDY: PC_OUT SHALL take the pending target (or the same-cycle new redirect, if present), then return to S_RUN.
REQ-025 S_PEND SHALL ignore PC_LD with PC_SEL==0.
REQ-026 A target with nonzero low ALIGN_BITS SHALL NOT be loaded or captured; it SHALL set PC_MISALIGN, with state unchanged.
REQ-027 PC_MISALIGN SHALL hold until MIS_CLR; if a set and MIS_CLR occur in the same cycle, set wins.
REQ-028 PC_PEND SHALL equal (state==S_PEND); PC_VALID SHALL equal (state!=S_BOOT).

Reset
REQ-029 On a CLK edge with RST_N=0: PC_OUT=RESET_VEC, state=S_BOOT, PC_PEND=0, PC_MISALIGN=0, pending register=0.
REQ-030 Reset mid-operation, including in S_PEND, SHALL discard the pending target, with reset taking priority over all inputs.

Structure
REQ-031 Package pc_gen_pkg SHALL hold the state enum (S_BOOT, S_RUN, S_PEND) and the select-width helper function.
REQ-032 The source selection SHALL be a parametrised combinational sub-module pc_src_mux (NUM_SRC, XLEN) instantiated once.

Verification
REQ-033 Reset with RST_N=0 for 2 cycles, then release -> PC_OUT=0, PC_VALID=0 for 1 cycle, then 1.
REQ-034 PC_LD=1, PC_SEL=0, FETCH_RDY=1 for 3 cycles from PC 0 -> PC_OUT sequence 4, 8, 12.
REQ-035 PC_SEL=2, PC_SRC_IN[2]=32'h100, FETCH_RDY=0 -> PC_PEND=1 and PC unchanged; then a second redirect PC_SEL=1 to 32'h200 while stalled; then FETCH_RDY=1 -> PC_OUT=32'h200 and PC_PEND=0.
REQ-036 Redirect target 32'h102 -> PC unchanged and PC_MISALIGN=1; then MIS_CLR with a simultaneous misaligned redirect -> PC_MISALIGN stays 1.
REQ-037 PC=32'hFFFF_FFFC with sequential advance -> PC_OUT=0 (wrap).
REQ-038 RST_N=0 while in S_PEND -> PC_OUT=RESET_VEC, PC_PEND=0, and the pending target is never applied.
